// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between display scanout and a
// draw-engine writer. Display words (4 x RGB332 pixels) are prefetched into
// a 4-entry FIFO and unpacked byte 0 first. The writer receives every slot
// the display does not urgently need.
//
// Port pipeline: grant decided in cycle t, mem_* driven in t+1,
// read data returned in t+2 and pushed at the end of t+2.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no display fetch (after reset, or whole frame already read)
// ST_FETCH  | prefetching display words for the current frame

module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int AW       = 17
) (
    input  logic          dclk,
    input  logic          clr_n,
    input  logic          frame_start,
    input  logic          pix_rd,
    output logic [7:0]    pix_data,
    output logic          underrun,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    output logic          wr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int            WORDS     = H_ACTIVE * V_ACTIVE / 4;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    fetch_state_t  state;
    fetch_state_t  state_nxt;

    logic          gnt_rd;
    logic          gnt_wr;
    logic          fetch_ok;
    logic          wr_ok;

    logic [AW-1:0] disp_addr;

    // rd_v1: a display read is on the RAM port this cycle
    // rd_v2: its data is on mem_rdata this cycle and should be pushed
    logic          rd_v1;
    logic          rd_v2;

    logic [31:0]   fifo_mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    fifo_count;
    logic [1:0]    idx;

    logic [2:0]    inflight;
    logic [2:0]    occ;
    logic          urgent;
    logic          room;
    logic          fifo_nonempty;
    logic          push;
    logic          pop;
    logic [31:0]   head_word;

    // Occupancy seen by the arbiter counts words already requested but not yet stored.
    always_comb begin
        inflight      = {2'b00, rd_v1} + {2'b00, rd_v2};
        occ           = fifo_count + inflight;
        urgent        = (occ <= 3'd1);
        room          = (occ < 3'd4);
        fifo_nonempty = (fifo_count != 3'd0);
        push          = rd_v2;
        pop           = pix_rd && fifo_nonempty && (idx == 2'd3);
    end

    // Fetch-enable state register.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection and fetch-enable next state. No display read is granted
    // in a frame_start cycle because disp_addr is being rewound; a write may
    // still go out.
    always_comb begin
        state_nxt = state;
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        fetch_ok  = (state == ST_FETCH) && !frame_start;
        wr_ok     = wr_req && !wr_ack;

        if (fetch_ok && urgent) begin
            gnt_rd = 1'b1;
        end else if (wr_ok) begin
            gnt_wr = 1'b1;
        end else if (fetch_ok && room) begin
            gnt_rd = 1'b1;
        end

        if (frame_start) begin
            state_nxt = ST_FETCH;
        end else if (gnt_rd && (disp_addr == LAST_ADDR)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Registered RAM port; all fields return to zero on idle cycles.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            wr_ack    <= 1'b0;
        end else begin
            mem_en    <= gnt_rd || gnt_wr;
            mem_we    <= gnt_wr;
            wr_ack    <= gnt_wr;
            if (gnt_wr) begin
                mem_be    <= wr_be;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (gnt_rd) begin
                mem_be    <= 4'hF;
                mem_addr  <= disp_addr;
                mem_wdata <= 32'h0;
            end else begin
                mem_be    <= 4'h0;
                mem_addr  <= '0;
                mem_wdata <= 32'h0;
            end
        end
    end

    // Display address and read-return tracking; frame_start drops anything in flight.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            disp_addr <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
        end else if (frame_start) begin
            disp_addr <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
        end else begin
            rd_v1 <= gnt_rd;
            rd_v2 <= rd_v1;
            if (gnt_rd) begin
                disp_addr <= disp_addr + AW'(1);
            end
        end
    end

    // FIFO pointers, byte index and the sticky underrun flag.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            idx        <= 2'd0;
            underrun   <= 1'b0;
        end else if (frame_start) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            idx        <= 2'd0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (pix_rd) begin
                if (fifo_nonempty) begin
                    idx <= idx + 2'd1;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge dclk) begin
        if (push && !frame_start) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Current pixel: selected byte of the head word, zero when nothing is buffered.
    always_comb begin
        head_word = fifo_mem[rd_ptr];
        pix_data  = 8'h00;
        if (fifo_nonempty) begin
            pix_data = head_word[{idx, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a one-cycle-latency RAM model.
// A short frame (640 x 4 -> 640 words) keeps the frame-end scenario brief.

module tb_vga_fb_arbiter;

    localparam int H     = 640;
    localparam int V     = 4;
    localparam int AW    = 17;
    localparam int WORDS = H * V / 4;
    localparam int WBASE = 100000;
    localparam logic [63:0] UNPACK_EXP = 64'h8877665544332211;

    logic          dclk;
    logic          clr_n;
    logic          frame_start;
    logic          pix_rd;
    logic [7:0]    pix_data;
    logic          underrun;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   ram [0:131071];

    int checks   = 0;
    int failures = 0;

    vga_fb_arbiter #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .AW       (AW)
    ) dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .underrun    (underrun),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .wr_ack      (wr_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial dclk = 1'b0;
    always #20 dclk = ~dclk;

    // RAM model: contents initialised here, then one-cycle read latency and byte writes.
    initial begin
        for (int i = 0; i < 131072; i++) begin
            ram[i] = 32'(i) * 32'h01010101 + 32'h40302010;
        end
        ram[0] = 32'h44332211;
        ram[1] = 32'h88776655;
        forever begin
            @(posedge dclk);
            if (mem_en) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end else begin
                    mem_rdata <= ram[mem_addr];
                end
            end
        end
    end

    function automatic logic [7:0] exp_pix(input int p);
        logic [31:0] w;
        w = ram[p / 4];
        return w[8*(p % 4) +: 8];
    endfunction

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic do_frame_start(input logic with_rd);
        frame_start = 1'b1;
        pix_rd      = with_rd;
        step();
        frame_start = 1'b0;
        pix_rd      = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        seen = 0;
        step(); step(); step();
        checks++;
        if ({pix_data, underrun, wr_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs pix=%h und=%b ack=%b en=%b addr=%h, all must be 0",
                     pix_data, underrun, wr_ack, mem_en, mem_addr);
        end
        clr_n = 1'b1;
        repeat (5) begin
            step();
            if (mem_en) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL no_fetch_before_frame_start got %0d reads, expected 0", seen);
        end
        do_frame_start(1'b0);
        step(); step(); step(); step();
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, AW'(3)}) begin
            failures++;
            $display("FAIL pre_reset_read en=%b addr=%0d, expected en=1 addr=3", mem_en, mem_addr);
        end
        checks++;
        if (pix_data !== 8'h11) begin
            failures++;
            $display("FAIL pre_reset_fifo pix=%h, expected 11", pix_data);
        end
        #5;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({pix_data, underrun, wr_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs pix=%h en=%b we=%b be=%h addr=%h, all must be 0",
                     pix_data, mem_en, mem_we, mem_be, mem_addr);
        end
        step(); step();
        clr_n = 1'b1;
        step();
        do_frame_start(1'b0);
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(0)}) begin
            failures++;
            $display("FAIL first_read_after_reset en=%b we=%b addr=%0d, expected 1 0 0",
                     mem_en, mem_we, mem_addr);
        end
    endtask

    task automatic test_prefetch();
        step(); step(); step(); step();
        do_frame_start(1'b0);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (k >= 2 && k <= 5) begin
                if ({mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, AW'(k - 2)}) begin
                    failures++;
                    $display("FAIL prefetch_read k=%0d en=%b we=%b be=%h addr=%0d, expected 1 0 f %0d",
                             k, mem_en, mem_we, mem_be, mem_addr, k - 2);
                end
            end else if (mem_en !== 1'b0) begin
                failures++;
                $display("FAIL prefetch_idle k=%0d en=%b, expected 0", k, mem_en);
            end
            step();
        end
    endtask

    task automatic test_unpack();
        logic [63:0] ue;
        ue = UNPACK_EXP;
        for (int i = 0; i < 8; i++) begin
            pix_rd = 1'b1;
            checks++;
            if (pix_data !== ue[8*i +: 8]) begin
                failures++;
                $display("FAIL unpack_pix i=%0d got %h, expected %h", i, pix_data, ue[8*i +: 8]);
            end
            checks++;
            if (i == 5) begin
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(4)}) begin
                    failures++;
                    $display("FAIL unpack_refill en=%b addr=%0d, expected read of 4", mem_en, mem_addr);
                end
            end else if (mem_en !== 1'b0) begin
                failures++;
                $display("FAIL unpack_no_read i=%0d en=%b, expected 0", i, mem_en);
            end
            step();
        end
        pix_rd = 1'b0;
    endtask

    task automatic test_underrun();
        do_frame_start(1'b0);
        pix_rd = 1'b1;
        checks++;
        if (pix_data !== 8'h00) begin
            failures++;
            $display("FAIL empty_pix got %h, expected 00", pix_data);
        end
        step();
        pix_rd = 1'b0;
        checks++;
        if ({underrun, pix_data} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL underrun_set und=%b pix=%h, expected 1 00", underrun, pix_data);
        end
        repeat (8) step();
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_sticky got %b, expected 1", underrun);
        end
        checks++;
        if (pix_data !== 8'h11) begin
            failures++;
            $display("FAIL underrun_no_ptr_move pix=%h, expected 11", pix_data);
        end
        do_frame_start(1'b1);
        checks++;
        if ({underrun, pix_data} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL underrun_cleared und=%b pix=%h, expected 0 00", underrun, pix_data);
        end
    endtask

    task automatic test_contention();
        logic [3:0] be_tab [4];
        int   rd_exp;
        int   pix;
        int   nwr;
        logic prev_ack;
        be_tab[0] = 4'b0010;
        be_tab[1] = 4'b1111;
        be_tab[2] = 4'b0001;
        be_tab[3] = 4'b1100;
        rd_exp   = 0;
        pix      = 0;
        nwr      = 0;
        prev_ack = 1'b0;
        do_frame_start(1'b0);
        wr_req  = 1'b1;
        wr_addr = AW'(WBASE);
        wr_data = 32'hC0DE0000;
        wr_be   = be_tab[0];
        for (int c = 0; c < 12 + 640 + 7; c++) begin
            if (mem_en && !mem_we) begin
                checks++;
                if (mem_addr !== AW'(rd_exp)) begin
                    failures++;
                    $display("FAIL contention_read_order got %0d, expected %0d", mem_addr, rd_exp);
                end
                rd_exp++;
            end
            if (mem_en && mem_we) begin
                checks++;
                if ({mem_addr, mem_be, mem_wdata} !== {wr_addr, wr_be, wr_data}) begin
                    failures++;
                    $display("FAIL contention_write addr=%0d be=%b data=%h, expected %0d %b %h",
                             mem_addr, mem_be, mem_wdata, wr_addr, wr_be, wr_data);
                end
            end
            checks++;
            if (wr_ack !== (mem_en && mem_we)) begin
                failures++;
                $display("FAIL wr_ack_with_write ack=%b en=%b we=%b", wr_ack, mem_en, mem_we);
            end
            if (wr_ack) begin
                checks++;
                if (prev_ack) begin
                    failures++;
                    $display("FAIL wr_ack_spacing adjacent acks at cycle %0d", c);
                end
            end
            prev_ack = wr_ack;
            if (wr_ack) begin
                nwr++;
                wr_addr = AW'(WBASE + nwr);
                wr_data = 32'hC0DE0000 + 32'(nwr);
                wr_be   = be_tab[nwr % 4];
            end
            pix_rd = (c >= 12) && (c < 12 + 640);
            if (pix_rd) begin
                checks++;
                if (pix_data !== exp_pix(pix)) begin
                    failures++;
                    $display("FAIL contention_pix p=%0d got %h, expected %h", pix, pix_data, exp_pix(pix));
                end
                pix++;
            end
            step();
        end
        pix_rd = 1'b0;
        wr_req = 1'b0;
        repeat (4) step();
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL contention_underrun got %b, expected 0", underrun);
        end
        checks++;
        if (rd_exp < 160) begin
            failures++;
            $display("FAIL contention_read_count got %0d, expected at least 160", rd_exp);
        end
        checks++;
        if (nwr < 250) begin
            failures++;
            $display("FAIL contention_write_count got %0d, expected at least 250", nwr);
        end
    endtask

    task automatic test_frame_end();
        int rd_exp;
        int pix;
        int last;
        rd_exp = 0;
        pix    = 0;
        last   = -1;
        do_frame_start(1'b0);
        for (int c = 0; c < 12 + WORDS * 4 + 20; c++) begin
            if (mem_en && !mem_we) begin
                checks++;
                if (mem_addr !== AW'(rd_exp)) begin
                    failures++;
                    $display("FAIL frame_read_order got %0d, expected %0d", mem_addr, rd_exp);
                end
                rd_exp++;
                last = int'(mem_addr);
            end
            pix_rd = (c >= 12) && (c < 12 + WORDS * 4);
            if (pix_rd) begin
                checks++;
                if (pix_data !== exp_pix(pix)) begin
                    failures++;
                    $display("FAIL frame_pix p=%0d got %h, expected %h", pix, pix_data, exp_pix(pix));
                end
                pix++;
            end
            step();
        end
        pix_rd = 1'b0;
        checks++;
        if (rd_exp !== WORDS) begin
            failures++;
            $display("FAIL frame_read_count got %0d, expected %0d", rd_exp, WORDS);
        end
        checks++;
        if (last !== WORDS - 1) begin
            failures++;
            $display("FAIL frame_last_addr got %0d, expected %0d", last, WORDS - 1);
        end
        checks++;
        if ({underrun, mem_en, pix_data} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL frame_end_quiet und=%b en=%b pix=%h, expected 0 0 00", underrun, mem_en, pix_data);
        end
    endtask

    task automatic test_stale_restart();
        logic [63:0] ue;
        ue = UNPACK_EXP;
        do_frame_start(1'b0);
        step(); step(); step();
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, AW'(2)}) begin
            failures++;
            $display("FAIL stale_setup en=%b addr=%0d, expected 1 2", mem_en, mem_addr);
        end
        do_frame_start(1'b1);
        checks++;
        if ({underrun, pix_data} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL restart_flushed und=%b pix=%h, expected 0 00", underrun, pix_data);
        end
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(0)}) begin
            failures++;
            $display("FAIL restart_read_addr0 en=%b we=%b addr=%0d, expected 1 0 0", mem_en, mem_we, mem_addr);
        end
        checks++;
        if (pix_data !== 8'h00) begin
            failures++;
            $display("FAIL restart_stale_dropped pix=%h, expected 00", pix_data);
        end
        step(); step();
        for (int i = 0; i < 8; i++) begin
            pix_rd = 1'b1;
            checks++;
            if (pix_data !== ue[8*i +: 8]) begin
                failures++;
                $display("FAIL restart_pix i=%0d got %h, expected %h", i, pix_data, ue[8*i +: 8]);
            end
            step();
        end
        pix_rd = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL restart_underrun got %b, expected 0", underrun);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n       = 1'b0;
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = 32'h0;
        wr_be       = 4'h0;
        test_reset();
        test_prefetch();
        test_unpack();
        test_underrun();
        test_contention();
        test_frame_end();
        test_stale_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
